// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for a 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It sits
// beside the pipeline registers and performs three jobs:
//   - Load-use hazards: holds PC and IF/ID and inserts bubbles into ID/EX for
//     LOAD_STALL_CYCLES cycles.
//   - Control hazards: flushes wrong-path instructions. A taken branch is
//     resolved in MEM, jr in EX, and j/jal in ID. Priority is
//     branch > jr > jump > load-use.
//   - ALU operand forwarding: EX/MEM has priority over MEM/WB, and $zero is
//     never forwarded.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles per load-use hazard (1..3)
//   CNT_WIDTH          width of the performance counters
//
// Configuration macro
//   HAZARD_PERF_CNT_EN  when defined, stall_count/flush_count are saturating
//                       counters. When undefined, both are tied to zero.
//
// Ports
//   clk, reset                     clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt       source operands of the ID instruction
//   id_jump                        j/jal decoded in ID
//   ex_rs, ex_rt, ex_rd            register fields of the EX instruction
//   ex_mem_read, ex_jr             EX instruction is a load / a resolved jr
//   mem_reg_write, mem_rd          MEM-stage writeback
//   mem_branch_tkn                 taken beq/bne resolved in MEM
//   wb_reg_write, wb_rd            WB-stage writeback
//   pc_write, if_id_write          load enables for PC and IF/ID
//   if_id_flush, id_ex_flush,
//   ex_mem_flush                   pipeline-register flushes
//   fwd_a, fwd_b                   operand select: 00 regfile, 10 EX/MEM,
//                                  01 MEM/WB
//   stall_count, flush_count       performance counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rt,
  input  logic                 id_jump,
  input  logic [4:0]           ex_rs,
  input  logic [4:0]           ex_rt,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_jr,
  input  logic                 mem_reg_write,
  input  logic [4:0]           mem_rd,
  input  logic                 mem_branch_tkn,
  input  logic                 wb_reg_write,
  input  logic [4:0]           wb_rd,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // Loaded on entry to STALL. The hazard cycle itself is the first bubble,
  // so STALL covers the remaining LOAD_STALL_CYCLES-1 bubbles.
  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] stall_cnt_q, stall_cnt_d;
  logic       hz;

  assign hz = ex_mem_read && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // Stall/flush decode and FSM next state.
  // NOTE: a combinational block assigns a default to every output and next-state
  // signal first, so that no path leaves a value unassigned and infers a latch.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;

    if (mem_branch_tkn) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
      stall_cnt_d  = 2'd0;
    end else if (ex_jr) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      state_d      = RUN;
      stall_cnt_d  = 2'd0;
    end else if (id_jump) begin
      if_id_flush  = 1'b1;
      state_d      = RUN;
      stall_cnt_d  = 2'd0;
    end else if (state_q == STALL) begin
      // The bubble continues whether or not hz is still visible.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
      stall_cnt_d  = stall_cnt_q - 2'd1;
      if (stall_cnt_q <= 2'd1) begin
        state_d     = RUN;
        stall_cnt_d = 2'd0;
      end
    end else if (hz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d     = STALL;
        stall_cnt_d = STALL_INIT;
      end
    end

    // The pipeline stays frozen and cleared for as long as reset is asserted.
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so that every flop
  // samples values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      stall_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Forwarding: the newer result in EX/MEM wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs))
      fwd_a = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs))
      fwd_a = 2'b01;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rt))
      fwd_b = 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rt))
      fwd_b = 2'b01;
    if (!reset) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_count_q, flush_count_q;
  logic                 any_flush;

  assign any_flush = if_id_flush | id_ex_flush | ex_mem_flush;

  // Saturating counters. Reset cycles are excluded because the flops are held
  // in reset while the outputs show their reset values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (!pc_write && (stall_count_q != '1))
        stall_count_q <= stall_count_q + 1'b1;
      if (any_flush && (flush_count_q != '1))
        flush_count_q <= flush_count_q + 1'b1;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Testbench for pipeline_hazard_ctrl. It runs two instances side by side on
// the same inputs:
//   dut1  LOAD_STALL_CYCLES=1, CNT_WIDTH=16
//   dut3  LOAD_STALL_CYCLES=3, CNT_WIDTH=4   (saturates quickly)
//
// The reference model tracks how many bubbles are still owed after the
// current cycle. It also keeps integer counter totals that saturate at the
// counter width. Inputs change 1 time unit after the rising edge, and outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int MAX1 = 65535;
  localparam int MAX3 = 15;

  typedef struct packed {
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rt, id_jump, ex_mem_read, ex_jr;
  logic       mem_reg_write, mem_branch_tkn, wb_reg_write;

  logic        pc_write1, if_id_write1, if_id_flush1, id_ex_flush1, ex_mem_flush1;
  logic [1:0]  fwd_a1, fwd_b1;
  logic [15:0] stall_count1, flush_count1;
  logic        pc_write3, if_id_write3, if_id_flush3, id_ex_flush3, ex_mem_flush3;
  logic [1:0]  fwd_a3, fwd_b3;
  logic [3:0]  stall_count3, flush_count3;

  exp_t obs1, obs3;
  assign obs1 = {pc_write1, if_id_write1, if_id_flush1, id_ex_flush1, ex_mem_flush1, fwd_a1, fwd_b1};
  assign obs3 = {pc_write3, if_id_write3, if_id_flush3, id_ex_flush3, ex_mem_flush3, fwd_a3, fwd_b3};

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_jr(ex_jr),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_branch_tkn(mem_branch_tkn),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .pc_write(pc_write1), .if_id_write(if_id_write1), .if_id_flush(if_id_flush1),
    .id_ex_flush(id_ex_flush1), .ex_mem_flush(ex_mem_flush1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .stall_count(stall_count1), .flush_count(flush_count1)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_WIDTH(4)) dut3 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_jr(ex_jr),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_branch_tkn(mem_branch_tkn),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .pc_write(pc_write3), .if_id_write(if_id_write3), .if_id_flush(if_id_flush3),
    .id_ex_flush(id_ex_flush3), .ex_mem_flush(ex_mem_flush3),
    .fwd_a(fwd_a3), .fwd_b(fwd_b3),
    .stall_count(stall_count3), .flush_count(flush_count3)
  );

  int tests = 0;
  int fails = 0;

  // Model state: bubbles still owed after this cycle, plus counter totals.
  int rem1, rem3, sc1, fc1, sc3, fc3;

  // ---------------------------------------------------------------- model
  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 5'd0)                          return 2'b00;
    if (mem_reg_write && mem_rd == src)       return 2'b10;
    if (wb_reg_write && wb_rd == src)         return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_hz();
    return ex_mem_read && ex_rd != 0 &&
           (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
  endfunction

  function automatic exp_t ref_out(input int rem, input bit in_reset);
    exp_t e;
    if (in_reset) return '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00};
    e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ref_fwd(ex_rs), ref_fwd(ex_rt)};
    if (mem_branch_tkn)           begin e.if_id_flush = 1; e.id_ex_flush = 1; e.ex_mem_flush = 1; end
    else if (ex_jr)               begin e.if_id_flush = 1; e.id_ex_flush = 1; end
    else if (id_jump)             e.if_id_flush = 1;
    else if (rem > 0 || ref_hz()) begin e.pc_write = 0; e.if_id_write = 0; e.id_ex_flush = 1; end
    return e;
  endfunction

  function automatic int next_rem(input int rem, input int stall_len);
    if (mem_branch_tkn || ex_jr || id_jump) return 0;
    if (rem > 0)                            return rem - 1;
    if (ref_hz())                           return stall_len - 1;
    return 0;
  endfunction

  function automatic int sat_inc(input int v, input int max, input bit cond);
    return (cond && v < max) ? v + 1 : v;
  endfunction

  function automatic int exp_cnt(input int v);
    return PERF ? v : 0;
  endfunction

  // Advances the model and the clock by one rising edge, using the inputs
  // that the DUT sampled.
  task automatic tick();
    exp_t e1, e3;
    e1 = ref_out(rem1, 1'b0);
    e3 = ref_out(rem3, 1'b0);
    @(posedge clk);
    sc1  = sat_inc(sc1, MAX1, !e1.pc_write);
    fc1  = sat_inc(fc1, MAX1, e1.if_id_flush | e1.id_ex_flush | e1.ex_mem_flush);
    sc3  = sat_inc(sc3, MAX3, !e3.pc_write);
    fc3  = sat_inc(fc3, MAX3, e3.if_id_flush | e3.id_ex_flush | e3.ex_mem_flush);
    rem1 = next_rem(rem1, 1);
    rem3 = next_rem(rem3, 3);
    #1;
  endtask

  task automatic clear_inputs();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rt, id_jump, ex_mem_read, ex_jr}          = '0;
    {mem_reg_write, mem_branch_tkn, wb_reg_write}      = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rem1 = 0; rem3 = 0; sc1 = 0; fc1 = 0; sc3 = 0; fc3 = 0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = r; id_rs = r;
  endtask

  function automatic logic [4:0] rand_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    mem_reg_write = 1'b1; mem_rd = 5'd9; ex_rs = 5'd9; ex_rt = 5'd9;
    #3;
    tests++;
    if (obs1 !== exp_t'(9'b0_0_111_00_00)) begin
      fails++; $display("FAIL reset_outputs dut1: got %b want %b", obs1, 9'b0_0_111_00_00);
    end
    tests++;
    if (stall_count1 !== 16'd0 || flush_count1 !== 16'd0 || stall_count3 !== 4'd0 || flush_count3 !== 4'd0) begin
      fails++; $display("FAIL reset_counters: got %0d %0d %0d %0d want 0", stall_count1, flush_count1, stall_count3, flush_count3);
    end
    do_reset();
    @(negedge clk);
    tests++;
    if (obs1 !== exp_t'(9'b1_1_000_00_00) || obs3 !== exp_t'(9'b1_1_000_00_00)) begin
      fails++; $display("FAIL post_reset_idle: got %b / %b want %b", obs1, obs3, 9'b1_1_000_00_00);
    end
    tick();
  endtask

  task automatic test_load_use();
    int low1, low3;
    do_reset();
    set_load_use(5'd8);
    low1 = 0; low3 = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tests++;
        if (pc_write1 !== 1'b0 || id_ex_flush1 !== 1'b1 || if_id_write1 !== 1'b0) begin
          fails++; $display("FAIL load_use_first dut1: pc_write=%b id_ex_flush=%b want 0 1", pc_write1, id_ex_flush1);
        end
      end
      if (!pc_write1) low1++;
      if (!pc_write3) low3++;
      tick();
      clear_inputs();
    end
    tests++;
    if (low1 != 1) begin fails++; $display("FAIL stall_len_1: got %0d cycles want 1", low1); end
    tests++;
    if (low3 != 3) begin fails++; $display("FAIL stall_len_3: got %0d cycles want 3", low3); end
    tests++;
    if (stall_count1 !== 16'(exp_cnt(1)) || stall_count3 !== 4'(exp_cnt(3))) begin
      fails++; $display("FAIL stall_count_after_load_use: got %0d/%0d want %0d/%0d",
                        stall_count1, stall_count3, exp_cnt(1), exp_cnt(3));
    end
    // $zero destination and an unused rt field do not create hazards.
    set_load_use(5'd0);
    @(negedge clk);
    tests++;
    if (pc_write1 !== 1'b1) begin fails++; $display("FAIL hz_rd_zero: pc_write got %b want 1", pc_write1); end
    tick();
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd10; id_rt = 5'd10; id_uses_rt = 1'b0;
    @(negedge clk);
    tests++;
    if (pc_write1 !== 1'b1) begin fails++; $display("FAIL hz_rt_unused: pc_write got %b want 1", pc_write1); end
    id_uses_rt = 1'b1;
    #1;
    tests++;
    if (pc_write1 !== 1'b0) begin fails++; $display("FAIL hz_rt_used: pc_write got %b want 0", pc_write1); end
    tick();
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    mem_reg_write = 1'b1; wb_reg_write = 1'b1; mem_rd = 5'd9; wb_rd = 5'd9; ex_rs = 5'd9;
    ex_rt = 5'd9;
    @(negedge clk);
    tests++;
    if (fwd_a1 !== 2'b10 || fwd_b1 !== 2'b10) begin
      fails++; $display("FAIL fwd_exmem_priority: got %b %b want 10 10", fwd_a1, fwd_b1);
    end
    mem_reg_write = 1'b0;
    #1;
    tests++;
    if (fwd_a1 !== 2'b01 || fwd_b1 !== 2'b01) begin
      fails++; $display("FAIL fwd_memwb: got %b %b want 01 01", fwd_a1, fwd_b1);
    end
    mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
    #1;
    tests++;
    if (fwd_a1 !== 2'b00 || fwd_b1 !== 2'b00) begin
      fails++; $display("FAIL fwd_zero_reg: got %b %b want 00 00", fwd_a1, fwd_b1);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_flush_priority();
    do_reset();
    set_load_use(5'd8);
    mem_branch_tkn = 1'b1; ex_jr = 1'b1; id_jump = 1'b1;
    @(negedge clk);
    tests++;
    if (obs1 !== exp_t'(9'b1_1_111_00_00) || obs3 !== exp_t'(9'b1_1_111_00_00)) begin
      fails++; $display("FAIL branch_priority: got %b / %b want %b", obs1, obs3, 9'b1_1_111_00_00);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    tests++;
    if (flush_count1 !== 16'(exp_cnt(1)) || flush_count3 !== 4'(exp_cnt(1))) begin
      fails++; $display("FAIL flush_count_branch: got %0d/%0d want %0d", flush_count1, flush_count3, exp_cnt(1));
    end
    set_load_use(5'd8); ex_jr = 1'b1; id_jump = 1'b1;
    #1;
    tests++;
    if (obs1 !== exp_t'(9'b1_1_110_00_00)) begin
      fails++; $display("FAIL jr_priority: got %b want %b", obs1, 9'b1_1_110_00_00);
    end
    ex_jr = 1'b0;
    #1;
    tests++;
    if (obs1 !== exp_t'(9'b1_1_100_00_00)) begin
      fails++; $display("FAIL jump_priority: got %b want %b", obs1, 9'b1_1_100_00_00);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_stall_abort();
    do_reset();
    set_load_use(5'd8);
    @(negedge clk);
    tick();
    clear_inputs();
    id_jump = 1'b1;  // arrives during the 2nd stall cycle of dut3
    @(negedge clk);
    tests++;
    if (pc_write3 !== 1'b1 || if_id_flush3 !== 1'b1) begin
      fails++; $display("FAIL stall_abort_flush: pc_write=%b if_id_flush=%b want 1 1", pc_write3, if_id_flush3);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    tests++;
    if (pc_write3 !== 1'b1) begin fails++; $display("FAIL stall_abort_run: pc_write got %b want 1", pc_write3); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_load_use(5'd8);
    @(negedge clk);
    tick();
    clear_inputs();
    @(negedge clk);
    tests++;
    if (pc_write3 !== 1'b0) begin fails++; $display("FAIL second_stall_cycle: pc_write got %b want 0", pc_write3); end
    #2 reset = 1'b0;
    mem_reg_write = 1'b1; mem_rd = 5'd9; ex_rs = 5'd9;
    #1;
    tests++;
    if (obs3 !== exp_t'(9'b0_0_111_00_00) || stall_count3 !== 4'd0 || flush_count3 !== 4'd0) begin
      fails++; $display("FAIL reset_mid_stall: got %b cnt %0d/%0d want %b cnt 0/0",
                        obs3, stall_count3, flush_count3, 9'b0_0_111_00_00);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_inputs();
    rem1 = 0; rem3 = 0; sc1 = 0; fc1 = 0; sc3 = 0; fc3 = 0;
    @(negedge clk);
    tests++;
    if (pc_write3 !== 1'b1 || stall_count3 !== 4'd0 || flush_count3 !== 4'd0) begin
      fails++; $display("FAIL after_reset_release: pc_write=%b cnt %0d/%0d want 1 0/0",
                        pc_write3, stall_count3, flush_count3);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use(5'd12);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tests++;
      if (obs3 !== ref_out(rem3, 1'b0)) begin
        fails++; $display("FAIL sat_cycle%0d dut3: got %b want %b", c, obs3, ref_out(rem3, 1'b0));
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    tests++;
    if (stall_count3 !== 4'(exp_cnt(15)) || stall_count1 !== 16'(exp_cnt(20))) begin
      fails++; $display("FAIL stall_saturation: got %0d/%0d want %0d/%0d",
                        stall_count1, stall_count3, exp_cnt(20), exp_cnt(15));
    end
    tick();
  endtask

  task automatic test_random(input int n);
    do_reset();
    for (int i = 0; i < n; i++) begin
      id_rs = rand_reg(); id_rt = rand_reg(); ex_rs = rand_reg(); ex_rt = rand_reg();
      ex_rd = rand_reg(); mem_rd = rand_reg(); wb_rd = rand_reg();
      id_uses_rt     = 1'($urandom_range(0, 1));
      ex_mem_read    = 1'($urandom_range(0, 1));
      mem_reg_write  = 1'($urandom_range(0, 1));
      wb_reg_write   = 1'($urandom_range(0, 1));
      mem_branch_tkn = ($urandom_range(0, 9) == 0);
      ex_jr          = ($urandom_range(0, 9) == 0);
      id_jump        = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      tests++;
      if (obs1 !== ref_out(rem1, 1'b0)) begin
        fails++; $display("FAIL rand%0d dut1: got %b want %b", i, obs1, ref_out(rem1, 1'b0));
      end
      tests++;
      if (obs3 !== ref_out(rem3, 1'b0)) begin
        fails++; $display("FAIL rand%0d dut3: got %b want %b", i, obs3, ref_out(rem3, 1'b0));
      end
      tests++;
      if (stall_count1 !== 16'(exp_cnt(sc1)) || flush_count1 !== 16'(exp_cnt(fc1)) ||
          stall_count3 !== 4'(exp_cnt(sc3))  || flush_count3 !== 4'(exp_cnt(fc3))) begin
        fails++; $display("FAIL rand%0d counters: got %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                          stall_count1, flush_count1, stall_count3, flush_count3,
                          exp_cnt(sc1), exp_cnt(fc1), exp_cnt(sc3), exp_cnt(fc3));
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_flush_priority();
    test_stall_abort();
    test_reset_mid_stall();
    test_saturation();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
